// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: arbitrates two sram_like masters (m0 = instruction fetch,
// m1 = data) onto one shared sram_like slave. Only one transfer is in flight at a time.
// Build option: define SRAM_ARB_RR_EN for round-robin arbitration.
// Without it, arbitration is fixed priority with m1 ahead of m0.
module sram_like_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [1:0]        m0_size,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_addr_ok,
  output logic              m0_data_ok,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [1:0]        m1_size,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_addr_ok,
  output logic              m1_data_ok,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_req,
  output logic              s_wr,
  output logic [1:0]        s_size,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic              s_addr_ok,
  input  logic              s_data_ok,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              busy_o,
  output logic              err_o
);

  localparam int unsigned SIZE_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   grant_q, grant_d;
  logic   err_q, err_d;
  logic   arb_grant;
  logic   gnt_req;

`ifdef SRAM_ARB_RR_EN
  logic last_grant_q, last_grant_d;

  // Round-robin: on a tie the master that did not win last time gets the bus
  always_comb begin
    arb_grant = m1_req;
    if (m0_req && m1_req) begin
      arb_grant = ~last_grant_q;
    end
  end

  // last_grant follows every accepted address
  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == ADDR && gnt_req && s_addr_ok) begin
      last_grant_d = grant_q;
    end
  end

  // Round-robin history register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  // Fixed priority: m1 wins whenever it is requesting
  assign arb_grant = m1_req;
`endif

  assign gnt_req = grant_q ? m1_req : m0_req;

  // State, grant and sticky error registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      err_q   <= err_d;
    end
  end

  // Next state, routing of slave handshakes and slave-side request mux
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    err_d      = err_q | (s_data_ok & (state_q != DATA));
    s_req      = 1'b0;
    s_wr       = 1'b0;
    s_size     = SIZE_W'(0);
    s_addr     = ADDR_W'(0);
    s_wdata    = DATA_W'(0);
    m0_addr_ok = 1'b0;
    m1_addr_ok = 1'b0;
    m0_data_ok = 1'b0;
    m1_data_ok = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          grant_d = arb_grant;
          state_d = ADDR;
        end
      end
      ADDR: begin
        s_req   = gnt_req;
        s_wr    = grant_q ? m1_wr    : m0_wr;
        s_size  = grant_q ? m1_size  : m0_size;
        s_addr  = grant_q ? m1_addr  : m0_addr;
        s_wdata = grant_q ? m1_wdata : m0_wdata;
        if (grant_q) begin
          m1_addr_ok = s_addr_ok;
        end else begin
          m0_addr_ok = s_addr_ok;
        end
        // A request withdrawn before acceptance never reaches the slave
        if (!gnt_req) begin
          state_d = IDLE;
        end else if (s_addr_ok) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (grant_q) begin
          m1_data_ok = s_data_ok;
        end else begin
          m0_data_ok = s_data_ok;
        end
        if (s_data_ok) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read data goes to both masters; each qualifies it with its own data_ok
  assign m0_rdata = {DATA_W{resetn}} & s_rdata;
  assign m1_rdata = {DATA_W{resetn}} & s_rdata;

  assign busy_o = (state_q != IDLE);
  assign err_o  = err_q;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: reset, single master, contention, abort,
// stray data_ok and back-to-back spacing.
`timescale 1ns/1ps
module tb_sram_like_arbiter;

  logic        clock;
  logic        resetn;
  logic        m0_req, m0_wr, m0_addr_ok, m0_data_ok;
  logic [1:0]  m0_size;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_wr, m1_addr_ok, m1_data_ok;
  logic [1:0]  m1_size;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        s_req, s_wr, s_addr_ok, s_data_ok;
  logic [1:0]  s_size;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic        busy_o, err_o;

  int checks = 0;
  int errors = 0;

  sram_like_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .resetn(resetn),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_addr_ok(m0_addr_ok), .m0_data_ok(m0_data_ok),
    .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok),
    .m1_rdata(m1_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok),
    .s_rdata(s_rdata), .busy_o(busy_o), .err_o(err_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // From IDLE with requests already driven: expect master em to be served.
  // gap = cycles the slave stalls before accepting the address.
  task automatic serve(input logic em, input logic [31:0] ea, input logic ew,
                       input logic [31:0] ewd, input logic [31:0] rd, input int gap);
    #1;
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL arb_latency s_req got %b exp 0", s_req); end
    tick();
    for (int i = 0; i < gap; i++) begin
      checks++; if (m0_addr_ok !== 1'b0 || m1_addr_ok !== 1'b0) begin errors++; $display("FAIL stall_addr_ok got %b%b exp 00", m1_addr_ok, m0_addr_ok); end
      tick();
    end
    checks++; if (s_req !== 1'b1) begin errors++; $display("FAIL s_req got %b exp 1", s_req); end
    checks++; if (s_addr !== ea) begin errors++; $display("FAIL s_addr got %h exp %h", s_addr, ea); end
    checks++; if (s_wr !== ew) begin errors++; $display("FAIL s_wr got %b exp %b", s_wr, ew); end
    checks++; if (s_size !== 2'b10) begin errors++; $display("FAIL s_size got %b exp 10", s_size); end
    checks++; if (s_wdata !== ewd) begin errors++; $display("FAIL s_wdata got %h exp %h", s_wdata, ewd); end
    s_addr_ok = 1'b1;
    #1;
    checks++; if (m0_addr_ok !== ~em || m1_addr_ok !== em) begin errors++; $display("FAIL addr_ok_route got m1=%b m0=%b exp m1=%b", m1_addr_ok, m0_addr_ok, em); end
    tick();
    s_addr_ok = 1'b0;
    if (em) m1_req = 1'b0; else m0_req = 1'b0;
    s_data_ok = 1'b1;
    s_rdata   = rd;
    #1;
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL data_s_req got %b exp 0", s_req); end
    checks++; if (m0_data_ok !== ~em || m1_data_ok !== em) begin errors++; $display("FAIL data_ok_route got m1=%b m0=%b exp m1=%b", m1_data_ok, m0_data_ok, em); end
    checks++; if ((em ? m1_rdata : m0_rdata) !== rd) begin errors++; $display("FAIL rdata got %h exp %h", em ? m1_rdata : m0_rdata, rd); end
    tick();
    s_data_ok = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL back_to_idle busy got %b exp 0", busy_o); end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    checks++; if (busy_o !== 1'b0 || s_req !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL reset_state busy=%b s_req=%b err=%b exp 000", busy_o, s_req, err_o); end
    checks++; if (m0_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", m0_rdata); end
    resetn = 1'b1;
    tick();
    m0_req = 1'b1; m0_addr = 32'hBFC0_0000; m0_size = 2'b10;
    tick();
    checks++; if (s_req !== 1'b1 || busy_o !== 1'b1) begin errors++; $display("FAIL pre_reset_addr s_req=%b busy=%b exp 11", s_req, busy_o); end
    #2;
    resetn = 1'b0;
    #1;
    checks++; if (s_req !== 1'b0 || busy_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL async_reset s_req=%b busy=%b err=%b exp 000", s_req, busy_o, err_o); end
    repeat (3) @(posedge clock);
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL held_reset busy got %b exp 0", busy_o); end
    m0_req = 1'b0;
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_m0_read();
    m0_req = 1'b1; m0_wr = 1'b0; m0_size = 2'b10; m0_addr = 32'hBFC0_0000; m0_wdata = 32'h0;
    serve(1'b0, 32'hBFC0_0000, 1'b0, 32'h0, 32'h3C08_BFC0, 2);
  endtask

  task automatic test_contention();
    m0_wr = 1'b0; m0_size = 2'b10; m0_addr = 32'hBFC0_0004; m0_wdata = 32'h0;
    m1_wr = 1'b1; m1_size = 2'b10; m1_addr = 32'h8000_1000; m1_wdata = 32'h1234_5678;
`ifdef SRAM_ARB_RR_EN
    // history after the m0 read favours m1 first, then strict alternation
    for (int r = 0; r < 4; r++) begin
      m0_req = 1'b1; m1_req = 1'b1;
      if (r % 2 == 0) serve(1'b1, 32'h8000_1000, 1'b1, 32'h1234_5678, 32'h0000_0011, 0);
      else            serve(1'b0, 32'hBFC0_0004, 1'b0, 32'h0, 32'h0000_0022, 0);
    end
    m0_req = 1'b0; m1_req = 1'b0;
`else
    m0_req = 1'b1; m1_req = 1'b1;
    serve(1'b1, 32'h8000_1000, 1'b1, 32'h1234_5678, 32'h0000_0011, 0);
    serve(1'b0, 32'hBFC0_0004, 1'b0, 32'h0, 32'h0000_0022, 1);
`endif
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_after_normal got %b exp 0", err_o); end
  endtask

  task automatic test_abort();
    m0_req = 1'b1; m0_addr = 32'hBFC0_0100;
    tick();
    checks++; if (s_req !== 1'b1) begin errors++; $display("FAIL abort_addr s_req got %b exp 1", s_req); end
    m0_req = 1'b0;
    #1;
    checks++; if (s_req !== 1'b0 || m0_addr_ok !== 1'b0) begin errors++; $display("FAIL abort_drop s_req=%b addr_ok=%b exp 00", s_req, m0_addr_ok); end
    tick();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_idle busy got %b exp 0", busy_o); end
    m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 32'h8000_2000; m1_wdata = 32'h0;
    serve(1'b1, 32'h8000_2000, 1'b0, 32'h0, 32'hCAFE_0001, 1);
  endtask

  task automatic test_stray_data_ok();
    s_data_ok = 1'b1; s_rdata = 32'h5555_AAAA;
    #1;
    checks++; if (m0_data_ok !== 1'b0 || m1_data_ok !== 1'b0) begin errors++; $display("FAIL stray_fwd got m1=%b m0=%b exp 00", m1_data_ok, m0_data_ok); end
    tick();
    s_data_ok = 1'b0;
    #1;
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL stray_err got %b exp 1", err_o); end
    repeat (3) tick();
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err_o); end
    resetn = 1'b0;
    #1;
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_reset got %b exp 0", err_o); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 32'h8000_3000; m1_wdata = 32'h0;
    tick();
    s_addr_ok = 1'b1;
    #1;
    checks++; if (m1_addr_ok !== 1'b1) begin errors++; $display("FAIL b2b_addr_ok got %b exp 1", m1_addr_ok); end
    tick();
    s_addr_ok = 1'b0; s_data_ok = 1'b1; s_rdata = 32'h0BAD_F00D;
    #1;
    checks++; if (m1_data_ok !== 1'b1) begin errors++; $display("FAIL b2b_data_ok got %b exp 1", m1_data_ok); end
    tick();
    s_data_ok = 1'b0;
    #1;
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL b2b_gap1 s_req got %b exp 0", s_req); end
    tick();
    checks++; if (s_req !== 1'b1) begin errors++; $display("FAIL b2b_gap2 s_req got %b exp 1", s_req); end
    s_addr_ok = 1'b1;
    tick();
    s_addr_ok = 1'b0; m1_req = 1'b0; s_data_ok = 1'b1;
    tick();
    s_data_ok = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL b2b_end busy got %b exp 0", busy_o); end
  endtask

  initial begin
    resetn = 1'b0;
    m0_req = 1'b0; m0_wr = 1'b0; m0_size = 2'b00; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_wr = 1'b0; m1_size = 2'b00; m1_addr = 32'h0; m1_wdata = 32'h0;
    s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = 32'hDEAD_BEEF;
    test_reset();
    test_m0_read();
    test_contention();
    test_abort();
    test_stray_data_ok();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
Two-master to one-slave arbiter on the sram_like bus. Master 0 is the instruction fetch interface (ibus_sram); master 1 is the data interface. The slave is the shared sram_like port into the AXI bridge. The block serialises transactions with one outstanding transfer at a time and routes addr_ok, data_ok and rdata back to the owning master.

Parameters:
ADDR_W, 32, address width of all sram_like ports
DATA_W, 32, wdata/rdata width of all sram_like ports

Ports:
clock  in  1  system clock
resetn  in  1  asynchronous active-low reset
m0_req  in  1  inst request; held until m0_addr_ok
m0_wr  in  1  inst write flag (0 from ibus_sram)
m0_size  in  2  inst transfer size
m0_addr  in  ADDR_W  inst address
m0_wdata  in  DATA_W  inst write data
m0_addr_ok  out  1  inst address accepted
m0_data_ok  out  1  inst data returned
m0_rdata  out  DATA_W  inst read data
m1_req, m1_wr, m1_size, m1_addr, m1_wdata  in  same widths as m0  data-side request
m1_addr_ok, m1_data_ok  out  1  data-side handshake
m1_rdata  out  DATA_W  data-side read data
s_req  out  1  slave request
s_wr  out  1  slave write flag
s_size  out  2  slave size
s_addr  out  ADDR_W  slave address
s_wdata  out  DATA_W  slave write data
s_addr_ok  in  1  slave address accepted
s_data_ok  in  1  slave data valid
s_rdata  in  DATA_W  slave read data
busy_o  out  1  state != IDLE
err_o  out  1  sticky: data_ok received while no transfer was outstanding

Behaviour:
- States: IDLE, ADDR, DATA. Registered: state, grant (0/1), last_grant (RR only), err_o.
- Reset (resetn=0, asynchronous): state=IDLE, grant=0, last_grant=1, err_o=0. All outputs 0 while in reset.
- IDLE: s_req=0, both addr_ok/data_ok=0. If m0_req or m1_req is asserted, latch grant and go to ADDR the next edge. Arbitration latency is 1 cycle. Fixed priority: m1 wins when both are requesting.
- ADDR: s_req=grant's req, and s_wr/s_size/s_addr/s_wdata are muxed from the granted master. m<grant>_addr_ok = s_addr_ok; the other master's addr_ok=0.
  - s_addr_ok=1 -> DATA.
  - Granted req drops before s_addr_ok (abort) -> IDLE, with no slave transaction.
- DATA: s_req=0, and no new request is accepted. m<grant>_data_ok = s_data_ok; s_data_ok=1 -> IDLE. A new grant is possible on the next cycle, so the minimum spacing between back-to-back transactions is 1 idle cycle.
- Rdata: m0_rdata and m1_rdata are both driven from s_rdata at all times. Masters qualify rdata with their own data_ok.
- s_addr_ok and s_data_ok in the same cycle while in ADDR: go to DATA only. The slave must not return data before it accepts the address; this case does not occur.
- s_data_ok outside DATA: ignored (no data_ok forwarded) and err_o set to 1. err_o is cleared only by reset.
- Non-granted master: its req is held pending with no addr_ok. It is never dropped, and is served in the next IDLE.
- Slave outputs: driven 0 when state != ADDR, except that s_addr/s_wdata may hold the mux value. Verification checks only s_req, s_wr and s_size in those states.

Optional Feature:
Macro SRAM_ARB_RR_EN.
- Defined: round-robin arbitration. When both masters request in IDLE, grant goes to the master != last_grant. last_grant updates on every s_addr_ok.
- Undefined: fixed priority m1 > m0, and last_grant is not implemented.
- Single-requester behaviour is identical in both builds.

Test Plan:
- Reset: hold resetn=0 for 3 cycles mid-ADDR -> state IDLE, s_req=0, err_o=0 immediately (asynchronous).
- m0 alone, m0_addr=0xBFC00000, s_addr_ok 2 cycles later, s_data_ok with s_rdata=0x3C08BFC0 -> s_addr=0xBFC00000, s_wr=0, s_size=2'b10; then m0_addr_ok pulse followed by m0_data_ok with rdata 0x3C08BFC0; m1_* handshake signals stay 0.
- m0 and m1 both requesting in the same cycle (m1 write 0x12345678 to 0x80001000):
  - Fixed build: m1 is served first, then m0.
  - SRAM_ARB_RR_EN build: repeat 4 times -> grants alternate m1, m0, m1, m0.
- Abort: m0_req rises, then falls before s_addr_ok -> return to IDLE, no m0_addr_ok; a following m1_req completes normally.
- Stray s_data_ok in IDLE -> no m*_data_ok pulse, err_o=1 and stays set.
- Back-to-back: m1 holds req across two transactions -> second s_req asserts exactly 2 cycles after the first s_data_ok (1 idle cycle + arbitration).
